// File: rtl/serial_word_packer.sv
// serial_word_packer
// Assembles a framed serial bit stream into WIDTH-bit words for the clk_1
// write side of the dual-clock word buffer. A finished word is held while
// buffer_full is high and strobed with a one-cycle data_1_en pulse once the
// buffer can take it. Delivered words are counted; restarts mid-word,
// frame starts arriving while a word is held, and parity errors are flagged.
//
// Optional feature: define SERIAL_PACKER_PARITY_EN to expect one even-parity
// bit after the WIDTH data bits. Without it there is no PAR state and
// parity_err is tied low.
module serial_word_packer #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_1,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             ser_start,
  input  logic             buffer_full,
  output logic [WIDTH-1:0] data_1,
  output logic             data_1_en,
  output logic             overflow,
  output logic             resync,
  output logic             parity_err,
  output logic [7:0]       words_sent
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef SERIAL_PACKER_PARITY_EN
    PAR   = 2'd2,
`endif
    HOLD  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_d;
  logic             en_d, ovf_d, resync_d;
  logic [7:0]       words_d;
  logic [WIDTH-1:0] shifted, first_bit, word;
  logic             complete;
`ifdef SERIAL_PACKER_PARITY_EN
  logic             perr_d;
`endif

  // State and registered outputs; rst is synchronous and overrides everything.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_1) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      data_1     <= '0;
      data_1_en  <= 1'b0;
      overflow   <= 1'b0;
      resync     <= 1'b0;
      words_sent <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      data_1     <= data_d;
      data_1_en  <= en_d;
      overflow   <= ovf_d;
      resync     <= resync_d;
      words_sent <= words_d;
    end
  end

`ifdef SERIAL_PACKER_PARITY_EN
  // Parity error pulse register.
  always_ff @(posedge clk_1) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= perr_d;
  end
`else
  assign parity_err = 1'b0;
`endif

  // Next-state and next-output logic for the framing FSM.
  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    shifted   = MSB_FIRST ? {shreg_q[WIDTH-2:0], ser_in} : {ser_in, shreg_q[WIDTH-1:1]};
    first_bit = MSB_FIRST ? {{(WIDTH-1){1'b0}}, ser_in} : {ser_in, {(WIDTH-1){1'b0}}};
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_1;
    en_d      = 1'b0;
    ovf_d     = overflow;
    resync_d  = 1'b0;
    words_d   = words_sent;
    complete  = 1'b0;
    word      = '0;
`ifdef SERIAL_PACKER_PARITY_EN
    perr_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (ser_valid && ser_start) begin
          shreg_d = first_bit;
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_valid) begin
          if (ser_start) begin
            shreg_d  = first_bit;
            cnt_d    = CNT_W'(1);
            resync_d = 1'b1;
          end else begin
            shreg_d = shifted;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SERIAL_PACKER_PARITY_EN
              state_d = PAR;
`else
              complete = 1'b1;
              word     = shifted;
`endif
            end
          end
        end
      end
`ifdef SERIAL_PACKER_PARITY_EN
      PAR: begin
        if (ser_valid) begin
          if (ser_start) begin
            shreg_d  = first_bit;
            cnt_d    = CNT_W'(1);
            resync_d = 1'b1;
            state_d  = SHIFT;
          end else if (^{shreg_q, ser_in} == 1'b0) begin
            complete = 1'b1;
            word     = shreg_q;
          end else begin
            perr_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      HOLD: begin
        if (ser_valid && ser_start) ovf_d = 1'b1;
        if (!buffer_full) begin
          en_d    = 1'b1;
          words_d = words_sent + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A finished word is strobed at once if the buffer has room, else held.
    if (complete) begin
      data_d = word;
      if (!buffer_full) begin
        en_d    = 1'b1;
        words_d = words_sent + 8'd1;
        state_d = IDLE;
      end else begin
        state_d = HOLD;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_packer.sv
// Self-checking bench for serial_word_packer (WIDTH=16, MSB first).
// Directed table of frames, hand-written multi-cycle corner cases and a
// randomized run compared against a queue-based model of delivered words.
`timescale 1ns/1ps
module tb_serial_word_packer;
  localparam int WIDTH = 16;

  logic             clk_1 = 1'b0;
  logic             rst, ser_in, ser_valid, ser_start, buffer_full;
  logic [WIDTH-1:0] data_1;
  logic             data_1_en, overflow, resync, parity_err;
  logic [7:0]       words_sent;

  always #5 clk_1 = ~clk_1;

  serial_word_packer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
    .clk_1(clk_1), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_start(ser_start), .buffer_full(buffer_full), .data_1(data_1),
    .data_1_en(data_1_en), .overflow(overflow), .resync(resync),
    .parity_err(parity_err), .words_sent(words_sent)
  );

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [WIDTH-1:0] rx_q[$];
  logic [WIDTH-1:0] exp_q[$];
  int               resync_cnt = 0;
  logic             full_at_edge = 1'b0;

  typedef struct {
    logic [WIDTH-1:0] word;
    int               hold;
    logic [WIDTH-1:0] exp_data;
    logic [7:0]       exp_words;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Remember buffer_full as sampled at each active edge.
  always @(posedge clk_1) full_at_edge <= buffer_full;

  // Collect strobed words and pulses between edges.
  always @(negedge clk_1) begin
    if (data_1_en) begin
      rx_q.push_back(data_1);
      check("strobe_while_full", full_at_edge, 1'b0);
    end
    if (resync) resync_cnt++;
  end

  task automatic tick();
    @(posedge clk_1);
    #1;
  endtask

  task automatic drive_bit(input logic b, input logic st);
    ser_in    = b;
    ser_valid = 1'b1;
    ser_start = st;
    tick();
    ser_valid = 1'b0;
    ser_start = 1'b0;
    ser_in    = 1'b0;
  endtask

  // Sends one frame MSB first (plus even parity bit when enabled). With rnd
  // set, gaps and buffer_full vary; last_full is buffer_full at the final bit.
  task automatic send_frame(input logic [WIDTH-1:0] w, input bit rnd, output bit last_full);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (rnd) begin
        if (i != WIDTH - 1) begin
          for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end
        buffer_full = ($urandom_range(0, 3) == 0);
      end
      last_full = buffer_full;
      drive_bit(w[i], i == WIDTH - 1);
    end
`ifdef SERIAL_PACKER_PARITY_EN
    if (rnd) buffer_full = ($urandom_range(0, 3) == 0);
    last_full = buffer_full;
    drive_bit(^w, 1'b0);
`endif
  endtask

  vec_t             vecs[6];
  bit               lf;
  int               r0, rs0, m_words;
  logic [WIDTH-1:0] w;

  initial begin
    rst = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; ser_start = 1'b0; buffer_full = 1'b0;
    tick(); tick();
    check("rst_data", data_1, 0);
    check("rst_en", data_1_en, 0);
    check("rst_overflow", overflow, 0);
    check("rst_resync", resync, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_words", words_sent, 0);
    rst = 1'b0;
    tick();

    // Directed frames: hold = cycles buffer_full stays high after the frame.
    vecs[0] = '{16'hA5C3, 0, 16'hA5C3, 8'd1};
    vecs[1] = '{16'h1234, 5, 16'h1234, 8'd2};
    vecs[2] = '{16'h0000, 0, 16'h0000, 8'd3};
    vecs[3] = '{16'hFFFF, 2, 16'hFFFF, 8'd4};
    vecs[4] = '{16'h8001, 0, 16'h8001, 8'd5};
    vecs[5] = '{16'h7E18, 1, 16'h7E18, 8'd6};
    for (int v = 0; v < 6; v++) begin
      buffer_full = (vecs[v].hold > 0);
      r0 = rx_q.size();
      send_frame(vecs[v].word, 1'b0, lf);
      check("tbl_data", data_1, vecs[v].exp_data);
      check("tbl_en_after_last_bit", data_1_en, vecs[v].hold == 0);
      if (vecs[v].hold > 0) begin
        for (int h = 0; h < vecs[v].hold; h++) tick();
        check("tbl_no_strobe_while_full", rx_q.size() - r0, 0);
        check("tbl_held_data", data_1, vecs[v].exp_data);
        buffer_full = 1'b0;
        tick();
        check("tbl_en_on_release", data_1_en, 1'b1);
      end
      tick();
      check("tbl_single_pulse", data_1_en, 1'b0);
      check("tbl_words", words_sent, vecs[v].exp_words);
      check("tbl_one_strobe", rx_q.size() - r0, 1);
    end

    // Restart at bit 9, then a complete 0xFFFF frame.
    r0 = rx_q.size(); rs0 = resync_cnt;
    drive_bit(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0);
    send_frame(16'hFFFF, 1'b0, lf);
    tick();
    check("resync_pulses", resync_cnt - rs0, 1);
    check("resync_strobes", rx_q.size() - r0, 1);
    check("resync_word", rx_q[$], 16'hFFFF);
    check("resync_words", words_sent, 7);

    // Frame start while a word is held: overflow, held word still delivered.
    buffer_full = 1'b1;
    r0 = rx_q.size();
    send_frame(16'hBEEF, 1'b0, lf);
    check("ovf_before", overflow, 0);
    send_frame(16'h5555, 1'b0, lf);
    check("ovf_set", overflow, 1);
    check("ovf_no_strobe_held", rx_q.size() - r0, 0);
    buffer_full = 1'b0;
    tick();
    check("ovf_release_en", data_1_en, 1);
    check("ovf_release_data", data_1, 16'hBEEF);
    tick();
    send_frame(16'h0F0F, 1'b0, lf);
    check("ovf_next_data", data_1, 16'h0F0F);
    check("ovf_next_en", data_1_en, 1);
    check("ovf_sticky", overflow, 1);
    check("ovf_words", words_sent, 9);
    rst = 1'b1; tick(); rst = 1'b0;
    check("ovf_cleared_by_rst", overflow, 0);
    check("words_cleared_by_rst", words_sent, 0);

    // 256 back-to-back frames: no bits lost, counter wraps to 0.
    rx_q.delete(); exp_q.delete();
    for (int k = 1; k <= 256; k++) begin
      w = WIDTH'($urandom);
      exp_q.push_back(w);
      send_frame(w, 1'b0, lf);
      if (k == 255) check("wrap_words_255", words_sent, 255);
      if (k == 256) check("wrap_words_0", words_sent, 0);
    end
    tick();
    check("wrap_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) check("wrap_word", rx_q[i], exp_q[i]);

    // Randomized gaps, backpressure and stray idle bits against the model.
    rx_q.delete(); exp_q.delete();
    m_words = 0;
    for (int k = 0; k < 40; k++) begin
      w = WIDTH'($urandom);
      exp_q.push_back(w);
      m_words++;
      send_frame(w, 1'b1, lf);
      if (lf) begin
        for (int g = $urandom_range(0, 3); g > 0; g--) begin
          buffer_full = 1'($urandom_range(0, 1));
          tick();
        end
        buffer_full = 1'b0;
        tick();
      end else begin
        buffer_full = 1'b0;
        for (int g = $urandom_range(0, 2); g > 0; g--) drive_bit(1'($urandom_range(0, 1)), 1'b0);
      end
    end
    buffer_full = 1'b0;
    tick();
    check("rand_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) check("rand_word", rx_q[i], exp_q[i]);
    check("rand_words_sent", words_sent, m_words % 256);

    // rst on the edge that samples bit 7; the rest of the frame is ignored.
    r0 = rx_q.size();
    drive_bit(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0);
    rst = 1'b1;
    drive_bit(1'b1, 1'b0);
    rst = 1'b0;
    check("midrst_data", data_1, 0);
    check("midrst_en", data_1_en, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_resync", resync, 0);
    check("midrst_parity_err", parity_err, 0);
    check("midrst_words", words_sent, 0);
    for (int i = 0; i < 10; i++) drive_bit(1'b1, 1'b0);
    tick();
    check("midrst_no_strobe", rx_q.size() - r0, 0);
    check("midrst_words_after", words_sent, 0);

`ifdef SERIAL_PACKER_PARITY_EN
    // 0x0001 has odd weight: parity bit 1 is correct, 0 is an error.
    for (int i = WIDTH - 1; i >= 0; i--) drive_bit(i == 0, i == WIDTH - 1);
    drive_bit(1'b1, 1'b0);
    check("par_ok_en", data_1_en, 1);
    check("par_ok_data", data_1, 16'h0001);
    check("par_ok_no_err", parity_err, 0);
    tick();
    for (int i = WIDTH - 1; i >= 0; i--) drive_bit(i == 0, i == WIDTH - 1);
    drive_bit(1'b0, 1'b0);
    check("par_bad_err", parity_err, 1);
    check("par_bad_no_en", data_1_en, 0);
    tick();
    check("par_err_single", parity_err, 0);
    check("par_words", words_sent, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
